// File: rtl/geo_pkg.sv
// Shared geometry constants, pixel-depth encoding and write-request layout
// for the pixel address generator.
package geo_pkg;
  localparam int ADDR_W  = 20;
  localparam int ROW_W   = 24;
  localparam int BIT_W   = 27;
  localparam int COORD_W = 12;
  localparam int COLOR_W = 8;

  typedef enum logic [1:0] {
    BPP_1 = 2'd0,
    BPP_2 = 2'd1,
    BPP_4 = 2'd2,
    BPP_8 = 2'd3
  } bpp_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [2:0]         bitpos;
    logic [COLOR_W-1:0] color;
  } wr_req_t;
endpackage

// File: rtl/pixel_address_gen_if.sv
// Pixel input handshake plus memory write request bus.
// The master side is the address generator; the slave side is the environment.
interface pixel_address_gen_if;
  logic                              pixel_in_rdy;
  logic signed [geo_pkg::COORD_W-1:0] x_in;
  logic signed [geo_pkg::COORD_W-1:0] y_in;
  logic [geo_pkg::COLOR_W-1:0]        color_in;
  logic                              draw_busy;
  logic                              wr_ena;
  logic                              wr_ack;
  logic [geo_pkg::ADDR_W-1:0]         wr_addr;
  logic [2:0]                        wr_bitpos;
  logic [geo_pkg::COLOR_W-1:0]        wr_color;

  modport master (
    input  pixel_in_rdy, x_in, y_in, color_in, wr_ack,
    output draw_busy, wr_ena, wr_addr, wr_bitpos, wr_color
  );

  modport slave (
    output pixel_in_rdy, x_in, y_in, color_in, wr_ack,
    input  draw_busy, wr_ena, wr_addr, wr_bitpos, wr_color
  );
endinterface

// File: rtl/pixel_fifo.sv
// Registered first-word-fall-through FIFO of write requests with occupancy count.
module pixel_fifo
  import geo_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  wr_req_t                  push_data,
  input  logic                     pop,
  output wr_req_t                  head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = 1;
  localparam logic [PTR_W:0]   CNT_ONE  = 1;
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

  wr_req_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only legal when the head leaves on the same edge.
  assign do_push = push && ((count != CNT_FULL) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/pixel_address_gen.sv
// Clips signed pixel coordinates, converts them to byte address + bit offset
// for a 1/2/4/8 bpp bitmap, and queues write requests toward memory.
module pixel_address_gen
  import geo_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  pixel_address_gen_if.master   pix,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [COORD_W-1:0]    dest_width,
  input  logic [COORD_W-1:0]    max_x,
  input  logic [COORD_W-1:0]    max_y,
  input  logic [1:0]            bpp_sel,
  output logic                  clipped
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                accept;
  logic                in_range;
  logic                draw_busy;

  logic                s1_valid;
  logic [ROW_W-1:0]    s1_row;
  logic [COORD_W-1:0]  s1_x;
  logic [COLOR_W-1:0]  s1_color;
  bpp_e                s1_bpp;
  logic [ADDR_W-1:0]   s1_base;

  logic [ROW_W-1:0]    idx;
  logic [BIT_W-1:0]    bitoff;
  wr_req_t             s2_calc;
  logic                s2_valid;
  wr_req_t             s2_req;

  wr_req_t             head;
  logic                fifo_empty;
  logic [CNT_W-1:0]    fifo_count;
  logic [CNT_W:0]      occupancy;

  assign accept   = pix.pixel_in_rdy && !draw_busy;
  // Sign bit set means negative; otherwise an unsigned compare against the limit.
  assign in_range = !pix.x_in[COORD_W-1] && !pix.y_in[COORD_W-1] &&
                    (pix.x_in[COORD_W-1:0] <= max_x) &&
                    (pix.y_in[COORD_W-1:0] <= max_y);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      clipped  <= 1'b0;
      s1_row   <= '0;
      s1_x     <= '0;
      s1_color <= '0;
      s1_bpp   <= BPP_1;
      s1_base  <= '0;
    end else begin
      s1_valid <= accept && in_range;
      clipped  <= accept && !in_range;
      if (accept) begin
        s1_row   <= ROW_W'(pix.y_in[COORD_W-1:0]) * ROW_W'(dest_width);
        s1_x     <= pix.x_in[COORD_W-1:0];
        s1_color <= pix.color_in;
        s1_bpp   <= bpp_e'(bpp_sel);
        s1_base  <= base_addr;
      end
    end
  end

  assign idx    = s1_row + ROW_W'(s1_x);
  assign bitoff = BIT_W'(idx) << s1_bpp;

  always_comb begin
    s2_calc        = '0;
    s2_calc.addr   = ADDR_W'(ROW_W'(s1_base) + bitoff[BIT_W-1:3]);
    s2_calc.bitpos = bitoff[2:0];
    s2_calc.color  = s1_color;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_req   <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) s2_req <= s2_calc;
    end
  end

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (s2_valid),
    .push_data (s2_req),
    .pop       (pix.wr_ack),
    .head      (head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Pixels still in the pipeline reserve a FIFO slot, so a push never finds it full.
  assign occupancy = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(s1_valid) + (CNT_W+1)'(s2_valid);
  assign draw_busy = occupancy >= (CNT_W+1)'(FIFO_DEPTH);

  assign pix.draw_busy = draw_busy;
  assign pix.wr_ena    = !fifo_empty;
  assign pix.wr_addr   = head.addr;
  assign pix.wr_bitpos = head.bitpos;
  assign pix.wr_color  = head.color;
endmodule

// File: tb/tb_pixel_address_gen.sv
// Directed bench for pixel_address_gen: address math per depth, clipping,
// backpressure, ordering, latency and asynchronous reset.
module tb_pixel_address_gen;
  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] base_addr;
  logic [11:0] dest_width;
  logic [11:0] max_x;
  logic [11:0] max_y;
  logic [1:0]  bpp_sel;
  logic        clipped;

  pixel_address_gen_if bus ();

  pixel_address_gen #(
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pix        (bus),
    .base_addr  (base_addr),
    .dest_width (dest_width),
    .max_x      (max_x),
    .max_y      (max_y),
    .bpp_sel    (bpp_sel),
    .clipped    (clipped)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [30:0] got[$];
  int          clip_cnt = 0;
  int          ena_seen = 0;
  int          gi = 0;
  int          c0;
  int          e0;

  // Inputs change just after rising edges, so the falling edge sees a settled cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.wr_ena) ena_seen++;
      if (bus.wr_ena && bus.wr_ack) got.push_back({bus.wr_addr, bus.wr_bitpos, bus.wr_color});
      if (clipped) clip_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [30:0] entry(input int k);
    return (k < got.size()) ? got[k] : '1;
  endfunction

  function automatic logic [30:0] req(input logic [19:0] a, input logic [2:0] b, input logic [7:0] c);
    return {a, b, c};
  endfunction

  task automatic set_cfg(input logic [19:0] b, input logic [11:0] w, input logic [1:0] bpp);
    base_addr  = b;
    dest_width = w;
    bpp_sel    = bpp;
  endtask

  // Presents a pixel and holds it until the accept edge; returns 1 time unit after it.
  task automatic send(input logic signed [11:0] x, input logic signed [11:0] y, input logic [7:0] c);
    bit ok;
    ok = 1'b0;
    bus.x_in         = x;
    bus.y_in         = y;
    bus.color_in     = c;
    bus.pixel_in_rdy = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.draw_busy) begin
        ok = 1'b1;
        break;
      end
    end
    check("accept_in_time", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    bus.pixel_in_rdy = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    reset            = 1'b1;
    bus.pixel_in_rdy = 1'b0;
    bus.x_in         = '0;
    bus.y_in         = '0;
    bus.color_in     = '0;
    bus.wr_ack       = 1'b0;
    max_x            = 12'hFFF;
    max_y            = 12'hFFF;
    set_cfg(20'h0, 12'd640, 2'd3);

    #12;
    check("rst_wr_ena",    32'(bus.wr_ena),    32'd0);
    check("rst_draw_busy", 32'(bus.draw_busy), 32'd0);
    check("rst_clipped",   32'(clipped),       32'd0);
    check("rst_wr_addr",   32'(bus.wr_addr),   32'd0);
    check("rst_wr_bitpos", 32'(bus.wr_bitpos), 32'd0);
    check("rst_wr_color",  32'(bus.wr_color),  32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // 8 bpp, latency: wr_ena rises in the third cycle after the accept edge
    set_cfg(20'h01000, 12'd640, 2'd3);
    bus.wr_ack = 1'b1;
    send(12'sd10, 12'sd2, 8'hA5);
    @(negedge clk);
    check("lat_cycle1", 32'(bus.wr_ena), 32'd0);
    @(negedge clk);
    check("lat_cycle2", 32'(bus.wr_ena), 32'd0);
    @(negedge clk);
    check("lat_cycle3", 32'(bus.wr_ena), 32'd1);
    check("bpp8_addr",   32'(bus.wr_addr),   32'h0150A);
    check("bpp8_bitpos", 32'(bus.wr_bitpos), 32'd0);
    check("bpp8_color",  32'(bus.wr_color),  32'hA5);
    wait_cycles(2);
    check("bpp8_count", 32'(got.size() - gi), 32'd1);
    gi = got.size();

    // 1 bpp; config changed right after accept must not affect this pixel
    set_cfg(20'h0, 12'd640, 2'd0);
    send(12'sd13, 12'sd1, 8'h3C);
    set_cfg(20'h01000, 12'd10, 2'd3);
    wait_cycles(6);
    check("bpp1_count", 32'(got.size() - gi), 32'd1);
    check("bpp1_req",   32'(entry(gi)), 32'(req(20'h00051, 3'd5, 8'h3C)));
    gi = got.size();

    // 2 bpp then 4 bpp back to back with per-pixel config
    set_cfg(20'h00200, 12'd100, 2'd1);
    send(12'sd7, 12'sd3, 8'h11);
    set_cfg(20'h0, 12'd10, 2'd2);
    send(12'sd3, 12'sd0, 8'h22);
    wait_cycles(8);
    check("bpp2_4_count", 32'(got.size() - gi), 32'd2);
    check("bpp2_req",     32'(entry(gi)),     32'(req(20'h0024C, 3'd6, 8'h11)));
    check("bpp4_req",     32'(entry(gi + 1)), 32'(req(20'h00001, 3'd4, 8'h22)));
    gi = got.size();

    // Address wraps modulo 2^20
    set_cfg(20'hFFFF0, 12'd640, 2'd3);
    send(12'sd32, 12'sd0, 8'h77);
    wait_cycles(6);
    check("wrap_count", 32'(got.size() - gi), 32'd1);
    check("wrap_req",   32'(entry(gi)), 32'(req(20'h00010, 3'd0, 8'h77)));
    gi = got.size();

    // Clipping at the limits, then the inclusive corner is kept
    max_x = 12'd319;
    max_y = 12'd239;
    set_cfg(20'h0, 12'd640, 2'd3);
    c0 = clip_cnt;
    e0 = ena_seen;
    send(12'sd320, 12'sd5, 8'h01);
    send(-12'sd1, 12'sd0, 8'h02);
    send(12'sd5, 12'sd240, 8'h03);
    wait_cycles(6);
    check("clip_pulses",  32'(clip_cnt - c0), 32'd3);
    check("clip_no_ena",  32'(ena_seen - e0), 32'd0);
    check("clip_no_push", 32'(got.size() - gi), 32'd0);
    send(12'sd319, 12'sd239, 8'h5A);
    wait_cycles(6);
    check("corner_req",  32'(entry(gi)), 32'(req(20'h256BF, 3'd0, 8'h5A)));
    check("corner_kept", 32'(clip_cnt - c0), 32'd3);
    gi = got.size();
    max_x = 12'hFFF;
    max_y = 12'hFFF;

    // Backpressure: four held with wr_ack low, fifth stalled, then drain in order
    bus.wr_ack = 1'b0;
    for (int i = 0; i < 4; i++) send(12'(i), 12'sd0, 8'(8'h10 + i));
    check("busy_after_4", 32'(bus.draw_busy), 32'd1);
    bus.x_in         = 12'sd4;
    bus.y_in         = 12'sd0;
    bus.color_in     = 8'h14;
    bus.pixel_in_rdy = 1'b1;
    wait_cycles(6);
    check("busy_held",    32'(bus.draw_busy), 32'd1);
    check("held_ena",     32'(bus.wr_ena),    32'd1);
    check("held_head",    32'({bus.wr_addr, bus.wr_bitpos, bus.wr_color}), 32'(req(20'h0, 3'd0, 8'h10)));
    check("held_no_pops", 32'(got.size() - gi), 32'd0);
    bus.wr_ack = 1'b1;
    for (int i = 4; i < 8; i++) send(12'(i), 12'sd0, 8'(8'h10 + i));
    wait_cycles(10);
    check("drain_count", 32'(got.size() - gi), 32'd8);
    for (int i = 0; i < 8; i++)
      check($sformatf("drain_order_%0d", i), 32'(entry(gi + i)), 32'(req(20'(i), 3'd0, 8'(8'h10 + i))));
    gi = got.size();

    // Asynchronous reset with three queued and one in flight
    bus.wr_ack = 1'b0;
    send(12'sd100, 12'sd0, 8'hC0);
    send(12'sd101, 12'sd0, 8'hC1);
    send(12'sd102, 12'sd0, 8'hC2);
    wait_cycles(4);
    check("rst2_pre_ena", 32'(bus.wr_ena), 32'd1);
    send(12'sd103, 12'sd0, 8'hC3);
    check("rst2_pre_busy", 32'(bus.draw_busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("rst2_wr_ena",    32'(bus.wr_ena),    32'd0);
    check("rst2_draw_busy", 32'(bus.draw_busy), 32'd0);
    check("rst2_wr_addr",   32'(bus.wr_addr),   32'd0);
    @(posedge clk);
    #1;
    reset      = 1'b0;
    bus.wr_ack = 1'b1;
    gi = got.size();
    e0 = ena_seen;
    wait_cycles(10);
    check("rst2_no_ena",  32'(ena_seen - e0), 32'd0);
    check("rst2_no_emit", 32'(got.size() - gi), 32'd0);
    send(12'sd1, 12'sd0, 8'h99);
    wait_cycles(6);
    check("rst2_new_count", 32'(got.size() - gi), 32'd1);
    check("rst2_new_req",   32'(entry(gi)), 32'(req(20'h00001, 3'd0, 8'h99)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
